// File: rtl/julia_pkg.sv
// rtl/julia_pkg.sv - shared constants, state encodings and helpers for the Julia iterator
package julia_pkg;

    // Fractional bits of the signed Q4.12 operands.
    localparam int FRAC_BITS = 12;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // |z|^2 threshold of 4.0 expressed in the 2*frac product scale.
    function automatic logic signed [33:0] escape_thresh(input int frac);
        return 34'sd4 <<< (2 * frac);
    endfunction

    localparam logic signed [33:0] ESC_THRESH = escape_thresh(FRAC_BITS);

    // Clamp a wide signed intermediate into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/julia_iter_if.sv
// rtl/julia_iter_if.sv - pixel request/result bundle between requester and Julia iterator
// Ports (as members):
//   i_Start, i_ZRe, i_ZIm, i_CRe, i_CIm, i_MaxIter : request side, driven by the master
//   o_Ready, o_Valid, o_Iter, o_RGB               : result side, driven by the slave
interface julia_iter_if #(
    parameter int ITER_W = 8
);
    logic                     i_Start;
    logic signed [15:0]       i_ZRe;
    logic signed [15:0]       i_ZIm;
    logic signed [15:0]       i_CRe;
    logic signed [15:0]       i_CIm;
    logic [ITER_W-1:0]        i_MaxIter;
    logic                     o_Ready;
    logic                     o_Valid;
    logic [ITER_W-1:0]        o_Iter;
    logic [23:0]              o_RGB;

    modport master (
        output i_Start, i_ZRe, i_ZIm, i_CRe, i_CIm, i_MaxIter,
        input  o_Ready, o_Valid, o_Iter, o_RGB
    );

    modport slave (
        input  i_Start, i_ZRe, i_ZIm, i_CRe, i_CIm, i_MaxIter,
        output o_Ready, o_Valid, o_Iter, o_RGB
    );
endinterface

// File: rtl/julia_palette.sv
// rtl/julia_palette.sv - combinational iteration-count to {R,G,B} colour map
// Ports:
//   iter_i     : escape iteration count (low 8 bits)
//   interior_i : pixel never escaped; forces black
//   rgb_o      : 24-bit {R,G,B}
module julia_palette (
    input  logic [7:0]  iter_i,
    input  logic        interior_i,
    output logic [23:0] rgb_o
);
    always_comb begin
        rgb_o = 24'h000000;
        if (!interior_i) begin
            rgb_o = {iter_i[4:0], 3'b000, iter_i[5:0], 2'b00, 8'hFF - iter_i};
        end
    end
endmodule

// File: rtl/julia_iter.sv
// rtl/julia_iter.sv - per-pixel Julia set escape-time iterator with palette output
// Ports:
//   i_CLK   : clock, all state changes on rising edge
//   i_Reset : synchronous active-high reset
//   bus     : request (start, z, c, limit) and result (ready, valid, iter, rgb)
module julia_iter
    import julia_pkg::*;
#(
    parameter int FRAC_BITS = julia_pkg::FRAC_BITS,
    parameter int ITER_W    = 8
) (
    input  logic               i_CLK,
    input  logic               i_Reset,
    julia_iter_if.slave        bus
);
    localparam logic signed [33:0] THRESH = escape_thresh(FRAC_BITS);

    logic [1:0]         state_q, state_d;
    logic signed [15:0] zr_q, zr_d, zi_q, zi_d;
    logic signed [15:0] cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0]  lim_q, lim_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic [ITER_W-1:0]  res_iter_q, res_iter_d;
    logic               res_int_q, res_int_d;
    logic               valid_q;
    logic [ITER_W-1:0]  iter_q;
    logic [23:0]        rgb_q;

    logic signed [31:0] p_rr, p_ii, p_ri;
    logic signed [33:0] mag, diff, cross2, zr_w, zi_w;
    logic               escape;
    logic [31:0]        res_iter_ext;
    logic [23:0]        pal_rgb;

    // Full-precision products; nothing is dropped before the escape compare.
    always_comb begin
        p_rr   = zr_q * zr_q;
        p_ii   = zi_q * zi_q;
        p_ri   = zr_q * zi_q;
        mag    = 34'(p_rr) + 34'(p_ii);
        diff   = 34'(p_rr) - 34'(p_ii);
        cross2 = 34'(p_ri) <<< 1;
        zr_w   = (diff >>> FRAC_BITS) + 34'(cr_q);
        zi_w   = (cross2 >>> FRAC_BITS) + 34'(ci_q);
        escape = (mag > THRESH);
    end

    always_comb begin
        state_d    = state_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        cr_d       = cr_q;
        ci_d       = ci_q;
        lim_d      = lim_q;
        cnt_d      = cnt_q;
        res_iter_d = res_iter_q;
        res_int_d  = res_int_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    zr_d    = bus.i_ZRe;
                    zi_d    = bus.i_ZIm;
                    cr_d    = bus.i_CRe;
                    ci_d    = bus.i_CIm;
                    lim_d   = bus.i_MaxIter;
                    cnt_d   = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                // Escape wins over the limit test in the same cycle.
                if (escape) begin
                    res_iter_d = cnt_q;
                    res_int_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (cnt_q == lim_q) begin
                    res_iter_d = lim_q;
                    res_int_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    zr_d  = sat16(zr_w);
                    zi_d  = sat16(zi_w);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign res_iter_ext = 32'(res_iter_q);

    julia_palette u_palette (
        .iter_i     (res_iter_ext[7:0]),
        .interior_i (res_int_q),
        .rgb_o      (pal_rgb)
    );

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            zr_q       <= '0;
            zi_q       <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            lim_q      <= '0;
            cnt_q      <= '0;
            res_iter_q <= '0;
            res_int_q  <= 1'b0;
            valid_q    <= 1'b0;
            iter_q     <= '0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            cr_q       <= cr_d;
            ci_q       <= ci_d;
            lim_q      <= lim_d;
            cnt_q      <= cnt_d;
            res_iter_q <= res_iter_d;
            res_int_q  <= res_int_d;
            // The DONE cycle publishes the recorded result as a one-cycle pulse;
            // iter/rgb then hold until the next publish.
            valid_q    <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                iter_q <= res_iter_q;
                rgb_q  <= pal_rgb;
            end
        end
    end

    assign bus.o_Ready = (state_q == ST_IDLE);
    assign bus.o_Valid = valid_q;
    assign bus.o_Iter  = iter_q;
    assign bus.o_RGB   = rgb_q;

endmodule

// File: tb/tb_julia_iter.sv
// tb/tb_julia_iter.sv - scoreboard bench for julia_iter
module tb_julia_iter;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0]  iter;
        logic [23:0] rgb;
        int          due;
    } exp_t;

    exp_t sb[$];

    julia_iter_if #(.ITER_W(8)) bus ();

    julia_iter #(.FRAC_BITS(12), .ITER_W(8)) dut (
        .i_CLK   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("iter", 32'(bus.o_Iter), 32'(e.iter));
                chk("rgb", 32'(bus.o_RGB), 32'(e.rgb));
                chk("latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input logic [15:0] zr, input logic [15:0] zi,
                         input logic [15:0] cr, input logic [15:0] ci,
                         input logic [7:0] lim, input logic [7:0] ei,
                         input logic [23:0] erg, input bit push);
        int n;
        int acc;
        n = 0;
        while (!bus.o_Ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.o_Ready), 32'd1);
        bus.i_ZRe     = zr;
        bus.i_ZIm     = zi;
        bus.i_CRe     = cr;
        bus.i_CIm     = ci;
        bus.i_MaxIter = lim;
        bus.i_Start   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) sb.push_back('{ei, erg, acc + int'(ei) + 2});
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_Start   = 1'b0;
        bus.i_ZRe     = '0;
        bus.i_ZIm     = '0;
        bus.i_CRe     = '0;
        bus.i_CIm     = '0;
        bus.i_MaxIter = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.o_Valid), 32'd0);
        chk("rst_iter", 32'(bus.o_Iter), 32'd0);
        chk("rst_rgb", 32'(bus.o_RGB), 32'd0);
        chk("rst_ready", 32'(bus.o_Ready), 32'd1);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.o_Ready), 32'd1);
        @(negedge clk);

        // Interior pixel, then check results hold.
        issue(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd16, 8'd16, 24'h000000, 1'b1);
        @(negedge clk);
        chk("busy_not_ready", 32'(bus.o_Ready), 32'd0);
        drain();
        repeat (5) @(negedge clk);
        chk("hold_iter", 32'(bus.o_Iter), 32'd16);
        chk("hold_rgb", 32'(bus.o_RGB), 32'h000000);

        // Immediate escape, short orbit, limit 0.
        issue(16'h2800, 16'h0000, 16'h0000, 16'h0000, 8'd16, 8'd0, 24'h0000FF, 1'b1);
        drain();
        issue(16'h1000, 16'h0000, 16'h1000, 16'h0000, 8'd16, 8'd2, 24'h1008FD, 1'b1);
        drain();
        issue(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 8'd0, 24'h000000, 1'b1);
        drain();
        // |z|^2 exactly 4.0 on the imaginary axis and at z=-2: no escape until the next step.
        issue(16'h0000, 16'h2000, 16'h0000, 16'h0000, 8'd16, 8'd1, 24'h0804FE, 1'b1);
        drain();
        issue(16'hE000, 16'h0000, 16'h0000, 16'h0000, 8'd16, 8'd1, 24'h0804FE, 1'b1);
        drain();
        // Complex orbit: z=1.5i, c=i -> z'=-2.25+1i escapes at 1.
        issue(16'h0000, 16'h1800, 16'h0000, 16'h1000, 8'd16, 8'd1, 24'h0804FE, 1'b1);
        drain();
        // Unit circle orbit stays interior.
        issue(16'h0000, 16'h1000, 16'h0000, 16'h0000, 8'd8, 8'd8, 24'h000000, 1'b1);
        drain();

        // Saturation.
        issue(16'h7000, 16'h7000, 16'h7FFF, 16'h7FFF, 8'd4, 8'd0, 24'h0000FF, 1'b1);
        drain();
        issue(16'h1C00, 16'h0000, 16'h7FFF, 16'h0000, 8'd4, 8'd1, 24'h0804FE, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_zr", 32'(dut.zr_q), 32'h00007FFF);
        drain();

        // Start held high: accepts every N+3 = 5 cycles, three accepts expected.
        bus.i_ZRe     = 16'h1000;
        bus.i_ZIm     = 16'h0000;
        bus.i_CRe     = 16'h1000;
        bus.i_CIm     = 16'h0000;
        bus.i_MaxIter = 8'd16;
        bus.i_Start   = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        sb.push_back('{8'd2, 24'h1008FD, a + 4});
        sb.push_back('{8'd2, 24'h1008FD, a + 9});
        sb.push_back('{8'd2, 24'h1008FD, a + 14});
        while (cyc < a + 12) @(negedge clk);
        bus.i_Start = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        // Reset at iteration 5 of an interior pixel: abandoned, no result.
        issue(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd16, 8'd0, 24'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.o_Valid), 32'd0);
        chk("midrst_iter", 32'(bus.o_Iter), 32'd0);
        chk("midrst_rgb", 32'(bus.o_RGB), 32'd0);
        chk("midrst_ready", 32'(bus.o_Ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", 32'(bus.o_Ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("midrst_no_result", 32'(bus.o_Iter), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/julia_iter.md
JULIA_ITER -- requirements
Module: julia_iter

Interface
REQ-001 Parameter FRAC_BITS, default 12: fractional bits of all signed fixed-point operands (Q4.12).
REQ-002 Parameter ITER_W, default 8: width of the iteration counter and limit.
REQ-003 i_CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 i_Reset  input  1  reset; synchronous, active-high.
REQ-005 i_Start  input  1  request to compute one pixel; accepted only when o_Ready=1.
REQ-006 i_ZRe, i_ZIm  input  16 each  signed Q4.12 initial z; sampled on accept.
REQ-007 i_CRe, i_CIm  input  16 each  signed Q4.12 Julia constant c; sampled on accept.
REQ-008 i_MaxIter  input  ITER_W  iteration limit; sampled on accept.
REQ-009 o_Ready  output  1  high exactly when the block is in IDLE.
REQ-010 o_Valid  output  1  one-cycle pulse marking a new result.
REQ-011 o_Iter  output  ITER_W  escape iteration count of the last result.
REQ-012 o_RGB  output  24  colour of the last result, {R,G,B}, ready for the LCD timing stage's RGB input.

Function
REQ-013 States SHALL be IDLE, ITER and DONE.
REQ-014 In IDLE with i_Start=1, the block SHALL latch z, c and limit, clear the counter, and enter ITER; i_Start outside IDLE SHALL be ignored.
REQ-015 Each ITER cycle SHALL form full 32-bit products zr*zr, zi*zi, zr*zi and a 34-bit sum zr*zr+zi*zi, with no intermediate truncation.
REQ-016 Escape SHALL be declared when the sum exceeds 4.0, i.e. is strictly greater than 4 shifted left by 2*FRAC_BITS.
REQ-017 On escape, the block SHALL record o_Iter = counter and enter DONE.
REQ-018 If there is no escape and counter == limit, the block SHALL record o_Iter = limit, mark the pixel interior, and enter DONE.
REQ-019 Escape SHALL take priority over the limit test in the same cycle.
REQ-020 Otherwise the block SHALL update zr' = ((zr*zr - zi*zi) >>> FRAC_BITS) + cr and zi' = ((2*zr*zi) >>> FRAC_BITS) + ci, saturate each to the signed 16-bit range, increment the counter, and stay in ITER.
REQ-021 In DONE, o_Valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-022 Latency: o_Valid SHALL be high in the cycle N+2 clock edges after the accept edge, where N = o_Iter.
REQ-023 Palette: an interior pixel SHALL give o_RGB = 24'h000000.
REQ-024 Palette: an escaped pixel SHALL give R = {iter[4:0],3'b000}, G = {iter[5:0],2'b00}, B = 8'hFF - iter[7:0].
REQ-025 o_Iter and o_RGB SHALL hold their values until the next o_Valid.
REQ-026 A limit of 0 SHALL yield o_Iter = 0, coloured per REQ-023/REQ-024 by the first escape test.

Reset
REQ-027 While i_Reset=1, state SHALL be IDLE and o_Valid, o_Iter, o_RGB and the counter SHALL be 0.
REQ-028 o_Ready SHALL be 1 in the first cycle after i_Reset deasserts.
REQ-029 A reset during ITER or DONE SHALL abandon the computation with no o_Valid pulse.

Structure
REQ-030 A shared package julia_pkg SHALL hold FRAC_BITS, the escape threshold constant and the state encodings.
REQ-031 The palette SHALL be a combinational sub-module julia_palette (iteration count and interior flag in, 24-bit RGB out), driving a registered o_RGB.

Verification
REQ-032 Interior pixel: z=0, c=0, limit=16 -> o_Iter=16, o_RGB=24'h000000, o_Valid 18 edges after accept.
REQ-033 Immediate escape: z=(0x2800,0), c=0, limit=16 -> o_Iter=0, o_RGB=24'h0000FF, o_Valid 2 edges after accept.
REQ-034 Short orbit: z=(0x1000,0), c=(0x1000,0), limit=16 -> o_Iter=2 (|z|^2 = 4.0 not escaping), o_RGB=24'h1008FD, o_Valid 4 edges after accept.
REQ-035 Handshake: i_Start held high continuously -> accepted only in IDLE cycles, one o_Valid per accept, requests during ITER/DONE dropped.
REQ-036 Reset mid-ITER: assert i_Reset for 1 cycle at iteration 5 of a 16-limit interior pixel -> no o_Valid, o_Iter=0, o_Ready=1 next cycle.
REQ-037 Saturation: z=(0x7000,0x7000), c=(0x7FFF,0x7FFF), limit=4 -> o_Iter=0 with no wrap; with z=(0x1C00,0), c=(0x7FFF,0) the updated zr clamps to 0x7FFF.
